cute_lock_state_reg: RTL



---
 rtl/cute_lock_pkg.sv | 32 +++
 rtl/cute_lock_state_reg_key_window_counter.sv | 50 +++++
 rtl/cute_lock_state_reg.sv | 72 +++++++
 3 files changed

// File: rtl/cute_lock_pkg.sv
// Shared constants and helpers for Cute-Lock key-scheduled state registers.
// The slice helpers take widened vectors so one function serves every parameter set.
package cute_lock_pkg;

  localparam int unsigned DEF_KEY_W   = 18;
  localparam int unsigned DEF_STATE_W = 5;
  localparam int unsigned MAX_VEC_W   = 1024;
  localparam int unsigned MAX_FIELD_W = 64;

  typedef logic [MAX_VEC_W-1:0]   vec_t;
  typedef logic [MAX_FIELD_W-1:0] field_t;

  function automatic int unsigned clog2min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic field_t field_slice(input vec_t v, input int unsigned k,
                                         input int unsigned w);
    return field_t'(v >> (k * w));
  endfunction

  function automatic field_t key_slice(input vec_t keys, input int unsigned k,
                                       input int unsigned key_w);
    return field_slice(keys, k, key_w);
  endfunction

  function automatic field_t trap_slice(input vec_t traps, input int unsigned k,
                                        input int unsigned state_w);
    return field_slice(traps, k, state_w);
  endfunction

endpackage

// File: rtl/cute_lock_state_reg_key_window_counter.sv
// Window scheduler: counts WINDOW cycles per key window and steps the
// window index modulo N_KEYS; holds while en is low.
module key_window_counter
  import cute_lock_pkg::*;
#(
  parameter int unsigned WINDOW = 6,
  parameter int unsigned N_KEYS = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  output logic [clog2min1(N_KEYS)-1:0]   win_idx,
  output logic                           last
);

  localparam int unsigned CYC_W = clog2min1(WINDOW);
  localparam int unsigned IDX_W = clog2min1(N_KEYS);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_KEYS - 1);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [IDX_W-1:0] win_q, win_d;

  assign last    = (cyc_q == CYC_LAST);
  assign win_idx = win_q;

  always_comb begin
    cyc_d = cyc_q;
    win_d = win_q;
    if (en) begin
      if (last) begin
        cyc_d = '0;
        win_d = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      win_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/cute_lock_state_reg.sv
// Key-locked present-state register: commits nx_state only while keyinput
// matches the current window's key, otherwise loads that window's trap state.
module cute_lock_state_reg
  import cute_lock_pkg::*;
#(
  parameter int unsigned                   STATE_W     = DEF_STATE_W,
  parameter int unsigned                   KEY_W       = DEF_KEY_W,
  parameter int unsigned                   N_KEYS      = 6,
  parameter int unsigned                   WINDOW      = 6,
  parameter int unsigned                   RESET_STATE = 1,
  parameter logic [N_KEYS*KEY_W-1:0]       KEYS        = '0,
  parameter logic [N_KEYS*STATE_W-1:0]     TRAPS       = '0,
  parameter int unsigned                   STICKY      = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [KEY_W-1:0]               keyinput,
  input  logic [STATE_W-1:0]             nx_state,
  output logic [STATE_W-1:0]             pr_state,
  output logic [clog2min1(N_KEYS)-1:0]   win_idx,
  output logic                           key_ok,
  output logic                           fault
);

  logic [KEY_W-1:0]   key_sel;
  logic [STATE_W-1:0] trap_sel;
  logic [STATE_W-1:0] pr_state_q, pr_state_d;
  logic               fault_q, fault_d;
  logic               commit;

  key_window_counter #(
    .WINDOW (WINDOW),
    .N_KEYS (N_KEYS)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .win_idx (win_idx),
    .last    ()
  );

  assign key_sel  = KEY_W'(key_slice(vec_t'(KEYS), 32'(win_idx), KEY_W));
  assign trap_sel = STATE_W'(trap_slice(vec_t'(TRAPS), 32'(win_idx), STATE_W));
  assign key_ok   = (keyinput == key_sel);

  // Sticky mode uses the fault seen before this edge; the mismatch edge itself traps anyway.
  assign commit = key_ok && !((STICKY != 0) && fault_q);

  always_comb begin
    pr_state_d = pr_state_q;
    fault_d    = fault_q;
    if (en) begin
      pr_state_d = commit ? nx_state : trap_sel;
      if (!key_ok) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_state_q <= STATE_W'(RESET_STATE);
      fault_q    <= 1'b0;
    end else begin
      pr_state_q <= pr_state_d;
      fault_q    <= fault_d;
    end
  end

  assign pr_state = pr_state_q;
  assign fault    = fault_q;

endmodule
